// File: rtl/lc3_pkg.sv
// Shared LC3 definitions: address width, reset PC, and the fetch FSM state encodings.
package lc3_pkg;
    localparam int LC3_ADDR_W = 16;
    localparam logic [LC3_ADDR_W-1:0] LC3_RESET_PC = 16'h3000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } fetch_state_e;
endpackage

// File: rtl/fetch_unit.sv
// LC3 fetch stage: owns the PC, issues imem reads with an ack handshake, strobes decode.
// Optional FETCH_PERF_CNT_EN adds a saturating fetch_count output.
module fetch_unit
    import lc3_pkg::*;
#(
    parameter logic [LC3_ADDR_W-1:0] RESET_PC = LC3_RESET_PC,
    parameter int                    TIMEOUT  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_fetch,
    input  logic                  enable_updatePC,
    input  logic                  br_taken,
    input  logic [LC3_ADDR_W-1:0] taddr,
    input  logic                  imem_ack,
    output logic [LC3_ADDR_W-1:0] pc,
    output logic [LC3_ADDR_W-1:0] npc_out,
    output logic                  instrmem_rd,
    output logic                  enable_decode,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]           fetch_count,
`endif
    output logic                  fetch_err
);

    fetch_state_e          state;
    logic [7:0]            wait_cnt;
    logic                  redirect;
    logic [LC3_ADDR_W-1:0] pc_inc;

    assign redirect = enable_updatePC & br_taken;
    assign pc_inc   = pc + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            npc_out       <= '0;
            instrmem_rd   <= 1'b0;
            enable_decode <= 1'b0;
            fetch_err     <= 1'b0;
            wait_cnt      <= '0;
        end else begin
            enable_decode <= 1'b0;
            case (state)
                IDLE: begin
                    if (redirect)
                        pc <= taddr;
                    if (enable_fetch) begin
                        state       <= REQ;
                        instrmem_rd <= 1'b1;
                    end
                end
                REQ: begin
                    // A redirect wins over a coincident ack: the old fetch is dropped.
                    if (redirect) begin
                        pc       <= taddr;
                        wait_cnt <= '0;
                    end else if (imem_ack) begin
                        state         <= DONE;
                        instrmem_rd   <= 1'b0;
                        enable_decode <= 1'b1;
                        npc_out       <= pc_inc;
                        wait_cnt      <= '0;
                    end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                        state       <= ERR;
                        instrmem_rd <= 1'b0;
                        fetch_err   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    if (enable_updatePC)
                        pc <= br_taken ? taddr : pc_inc;
                    wait_cnt <= '0;
                    if (enable_fetch) begin
                        state       <= REQ;
                        instrmem_rd <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                ERR: begin
                    instrmem_rd <= 1'b0;
                    fetch_err   <= 1'b1;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fetch_count <= '0;
        else if (state == DONE && fetch_count != 16'hFFFF)
            fetch_count <= fetch_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized + directed bench for fetch_unit against a transaction-level reference model.
module tb_fetch_unit;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable_fetch = 1'b0, enable_updatePC = 1'b0, br_taken = 1'b0, imem_ack = 1'b0;
    logic [15:0] taddr = '0;
    logic [15:0] pc, npc_out;
    logic        instrmem_rd, enable_decode, fetch_err;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_count;
`endif

    fetch_unit #(.RESET_PC(16'h3000), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .enable_fetch(enable_fetch), .enable_updatePC(enable_updatePC),
        .br_taken(br_taken), .taddr(taddr), .imem_ack(imem_ack),
        .pc(pc), .npc_out(npc_out), .instrmem_rd(instrmem_rd), .enable_decode(enable_decode),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count(fetch_count),
`endif
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    bit chk_en = 0;

    // Reference model: what the fetch stage is doing (idle, waiting on memory,
    // delivering, dead) plus the addresses it holds.
    int          m_mode;   // 0 idle, 1 waiting, 2 delivering, 3 dead
    int          m_wait;
    logic [15:0] m_pc, m_npc;
    int          m_fetches;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_mode = 0; m_wait = 0; m_pc = 16'h3000; m_npc = 16'h0000; m_fetches = 0;
    endtask

    task automatic model_step();
        bit redir;
        redir = enable_updatePC && br_taken;
        case (m_mode)
            0: begin
                if (redir) m_pc = taddr;
                if (enable_fetch) begin m_mode = 1; m_wait = 0; end
            end
            1: begin
                if (redir) begin m_pc = taddr; m_wait = 0; end
                else if (imem_ack) begin m_mode = 2; m_npc = m_pc + 16'd1; end
                else begin
                    m_wait++;
                    if (m_wait >= TO) m_mode = 3;
                end
            end
            2: begin
                if (m_fetches < 65535) m_fetches++;
                if (enable_updatePC) m_pc = br_taken ? taddr : m_pc + 16'd1;
                m_mode = enable_fetch ? 1 : 0;
                m_wait = 0;
            end
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    // Compare process: every cycle, DUT outputs vs the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc", pc, m_pc);
            chk("npc_out", npc_out, m_npc);
            chk("instrmem_rd", 16'(instrmem_rd), 16'(m_mode == 1));
            chk("enable_decode", 16'(enable_decode), 16'(m_mode == 2));
            chk("fetch_err", 16'(fetch_err), 16'(m_mode == 3));
`ifdef FETCH_PERF_CNT_EN
            chk("fetch_count", fetch_count, 16'(m_fetches));
`endif
        end
    end

    task automatic do_reset();
        chk_en = 0;
        rst = 1'b1;
        enable_fetch = 0; enable_updatePC = 0; br_taken = 0; imem_ack = 0; taddr = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("rst_pc", pc, 16'h3000);
        chk("rst_npc", npc_out, 16'h0000);
        chk("rst_rd", 16'(instrmem_rd), 16'd0);
        chk("rst_err", 16'(fetch_err), 16'd0);
        chk_en = 1;
    endtask

    initial begin
        do_reset();

        // Sequential fetches, ack on first REQ cycle
        enable_fetch = 1; enable_updatePC = 1; br_taken = 0; imem_ack = 0;
        tick();
        chk("t2_req_pc", pc, 16'h3000);
        imem_ack = 1; tick();
        chk("t2_strobe0", 16'(enable_decode), 16'd1);
        chk("t2_npc0", npc_out, 16'h3001);
        imem_ack = 0; tick();
        chk("t2_req_pc1", pc, 16'h3001);
        imem_ack = 1; tick();
        chk("t2_npc1", npc_out, 16'h3002);
        imem_ack = 0; tick();
        imem_ack = 1; tick();
        chk("t2_npc2", npc_out, 16'h3003);

        // Branch taken while in DONE
        imem_ack = 0; br_taken = 1; taddr = 16'h4010; tick();
        chk("t3_pc", pc, 16'h4010);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_3", fetch_count, 16'd3);
`endif
        br_taken = 0; imem_ack = 1; tick();
        chk("t3_npc", npc_out, 16'h4011);

        // Redirect coincident with ack in REQ
        imem_ack = 0; tick();
        chk("t4_pc_old", pc, 16'h4011);
        br_taken = 1; taddr = 16'h5000; imem_ack = 1; tick();
        chk("t4_no_strobe", 16'(enable_decode), 16'd0);
        chk("t4_pc_new", pc, 16'h5000);
        br_taken = 0; tick();
        chk("t4_npc", npc_out, 16'h5001);

        // Wraparound at FFFF
        imem_ack = 0; br_taken = 1; taddr = 16'hFFFF; tick();
        br_taken = 0; imem_ack = 1; tick();
        chk("t6_npc_wrap", npc_out, 16'h0000);
        imem_ack = 0; tick();
        chk("t6_pc_wrap", pc, 16'h0000);

        // Reset asserted asynchronously mid-REQ
        #1;
        chk_en = 0;
        rst = 1'b1;
        #1;
        chk("t1_pc", pc, 16'h3000);
        chk("t1_rd", 16'(instrmem_rd), 16'd0);
        chk("t1_dec", 16'(enable_decode), 16'd0);
        do_reset();

        // Randomized traffic; ack forced before the timeout window closes
        for (int i = 0; i < 600; i++) begin
            enable_fetch    = ($urandom % 4) != 0;
            enable_updatePC = ($urandom % 4) != 0;
            br_taken        = ($urandom % 5) == 0;
            taddr           = (($urandom % 8) == 0) ? 16'hFFFF : 16'($urandom);
            imem_ack        = ($urandom % 2) || (m_mode == 1 && m_wait >= 5);
            tick();
        end

        // Timeout: no ack for TIMEOUT cycles, then acks ignored
        do_reset();
        enable_fetch = 1; enable_updatePC = 0; br_taken = 0; imem_ack = 0;
        tick();
        repeat (TO - 1) tick();
        chk("t5_pre_err", 16'(fetch_err), 16'd0);
        tick();
        chk("t5_err", 16'(fetch_err), 16'd1);
        chk("t5_rd", 16'(instrmem_rd), 16'd0);
        imem_ack = 1;
        repeat (4) tick();
        chk("t5_sticky", 16'(fetch_err), 16'd1);
        chk("t5_no_dec", 16'(enable_decode), 16'd0);

        @(negedge clk);
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
